// File: rtl/ht_delay_line.sv
// Valid/ready delay line for hash-table command beats: DELAY register stages,
// either a combinational ready chain or skid-buffer stages with a registered ready.
package hash_table;
    typedef enum logic [1:0] {
        HT_NOP    = 2'd0,
        HT_INSERT = 2'd1,
        HT_DELETE = 2'd2,
        HT_LOOKUP = 2'd3
    } ht_cmd_t;
endpackage

module ht_delay_stage #(
    parameter int WIDTH = 1,
    parameter int SKID  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             up_ready,
    output logic             dn_valid,
    output logic [WIDTH-1:0] dn_data,
    input  logic             dn_ready
);
    if (SKID != 0) begin : g_skid
        logic             main_vld;
        logic             skid_vld;
        logic [WIDTH-1:0] main_q;
        logic [WIDTH-1:0] skid_q;
        logic             main_free;

        assign main_free = !main_vld || dn_ready;

        // Skid entry refills the main register first, so ordering holds.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                main_vld <= 1'b0;
                skid_vld <= 1'b0;
                main_q   <= '0;
                skid_q   <= '0;
            end else if (main_free) begin
                if (skid_vld) begin
                    main_vld <= 1'b1;
                    main_q   <= skid_q;
                    skid_vld <= 1'b0;
                end else begin
                    main_vld <= up_valid;
                    if (up_valid) main_q <= up_data;
                end
            end else if (up_valid && !skid_vld) begin
                skid_vld <= 1'b1;
                skid_q   <= up_data;
            end
        end

        assign up_ready = !skid_vld;
        assign dn_valid = main_vld;
        assign dn_data  = main_q;
    end else begin : g_comb
        logic             vld;
        logic [WIDTH-1:0] q;

        // An empty stage accepts even while downstream is stalled.
        assign up_ready = !vld || dn_ready;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld <= 1'b0;
                q   <= '0;
            end else if (up_ready) begin
                vld <= up_valid;
                if (up_valid) q <= up_data;
            end
        end

        assign dn_valid = vld;
        assign dn_data  = q;
    end
endmodule

module ht_delay_line
    import hash_table::*;
#(
    parameter int KEY_WIDTH      = 32,
    parameter int VALUE_WIDTH    = 16,
    parameter int BUCKET_WIDTH   = 8,
    parameter int HEAD_PTR_WIDTH = 10,
    parameter int DELAY          = 1,
    parameter int PIPELINE_READY = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [KEY_WIDTH-1:0]      ht_in_key,
    input  logic [VALUE_WIDTH-1:0]    ht_in_value,
    input  ht_cmd_t                   ht_in_cmd,
    input  logic [BUCKET_WIDTH-1:0]   ht_in_bucket,
    input  logic [HEAD_PTR_WIDTH-1:0] ht_in_head_ptr,
    input  logic                      ht_in_head_ptr_val,
    input  logic                      ht_in_valid,
    output logic                      ht_in_ready,
    output logic [KEY_WIDTH-1:0]      ht_out_key,
    output logic [VALUE_WIDTH-1:0]    ht_out_value,
    output ht_cmd_t                   ht_out_cmd,
    output logic [BUCKET_WIDTH-1:0]   ht_out_bucket,
    output logic [HEAD_PTR_WIDTH-1:0] ht_out_head_ptr,
    output logic                      ht_out_head_ptr_val,
    output logic                      ht_out_valid,
    input  logic                      ht_out_ready
);
    if (DELAY < 0 || DELAY > 16) begin : g_bad_delay
        $error("ht_delay_line: DELAY=%0d is outside 0..16", DELAY);
    end

    typedef struct packed {
        logic [KEY_WIDTH-1:0]      key;
        logic [VALUE_WIDTH-1:0]    value;
        ht_cmd_t                   cmd;
        logic [BUCKET_WIDTH-1:0]   bucket;
        logic [HEAD_PTR_WIDTH-1:0] head_ptr;
        logic                      head_ptr_val;
    } beat_t;

    // Index 0 is the upstream side, index DELAY the downstream side.
    beat_t [DELAY:0] beat;
    logic  [DELAY:0] vld;

    assign beat[0] = {ht_in_key, ht_in_value, ht_in_cmd, ht_in_bucket,
                      ht_in_head_ptr, ht_in_head_ptr_val};
    assign vld[0]  = ht_in_valid;

    // Ready is kept per stage so the backward chain is a set of distinct nets.
    for (genvar k = 0; k < DELAY; k++) begin : g_stage
        logic up_rdy;
        logic dn_rdy;

        if (k == DELAY - 1) begin : g_last
            assign dn_rdy = ht_out_ready;
        end else begin : g_mid
            assign dn_rdy = g_stage[k+1].up_rdy;
        end

        ht_delay_stage #(
            .WIDTH($bits(beat_t)),
            .SKID (PIPELINE_READY)
        ) u_stage (
            .clk     (clk_i),
            .rst     (rst_i),
            .up_valid(vld[k]),
            .up_data (beat[k]),
            .up_ready(up_rdy),
            .dn_valid(vld[k+1]),
            .dn_data (beat[k+1]),
            .dn_ready(dn_rdy)
        );
    end

    if (DELAY == 0) begin : g_wire
        assign ht_in_ready = ht_out_ready;
    end else begin : g_pipe
        assign ht_in_ready = g_stage[0].up_rdy;
    end

    assign ht_out_valid        = vld[DELAY];
    assign ht_out_key          = beat[DELAY].key;
    assign ht_out_value        = beat[DELAY].value;
    assign ht_out_cmd          = beat[DELAY].cmd;
    assign ht_out_bucket       = beat[DELAY].bucket;
    assign ht_out_head_ptr     = beat[DELAY].head_ptr;
    assign ht_out_head_ptr_val = beat[DELAY].head_ptr_val;
endmodule

// File: tb/tb_ht_delay_line.sv
// Bench for ht_delay_line: six configurations checked against a FIFO scoreboard
// plus directed latency, capacity, reset and pass-through checks.
module tb_ht_delay_line;
    import hash_table::*;

    typedef struct packed {
        logic [31:0] key;
        logic [15:0] value;
        ht_cmd_t     cmd;
        logic [7:0]  bucket;
        logic [9:0]  head_ptr;
        logic        head_ptr_val;
    } beat_t;

    localparam int N = 6;
    // Instance g: DELAY = DLY[g], PIPELINE_READY = PRDY[g]
    localparam logic [N-1:0][4:0] DLY  = {5'd0, 5'd0, 5'd2, 5'd2, 5'd3, 5'd1};
    localparam logic [N-1:0]      PRDY = 6'b011000;

    logic clk = 1'b0;
    logic rst;
    beat_t [N-1:0] in_beat;
    beat_t [N-1:0] out_beat;
    logic  [N-1:0] in_valid, in_ready, out_valid, out_ready;

    int    n_cmp = 0;
    int    n_err = 0;
    int    cur, cyc, acc_cnt, out_cnt, ov_cnt;
    bit    lat_chk, stalled, in_fired;
    beat_t held;
    beat_t exp_q[$];
    int    acc_q[$];
    time   t_edge = 0;
    time   t_rst = 0;

    for (genvar g = 0; g < N; g++) begin : g_dut
        ht_delay_line #(
            .DELAY         (int'(DLY[g])),
            .PIPELINE_READY(int'(PRDY[g]))
        ) u_dut (
            .clk_i              (clk),
            .rst_i              (rst),
            .ht_in_key          (in_beat[g].key),
            .ht_in_value        (in_beat[g].value),
            .ht_in_cmd          (in_beat[g].cmd),
            .ht_in_bucket       (in_beat[g].bucket),
            .ht_in_head_ptr     (in_beat[g].head_ptr),
            .ht_in_head_ptr_val (in_beat[g].head_ptr_val),
            .ht_in_valid        (in_valid[g]),
            .ht_in_ready        (in_ready[g]),
            .ht_out_key         (out_beat[g].key),
            .ht_out_value       (out_beat[g].value),
            .ht_out_cmd         (out_beat[g].cmd),
            .ht_out_bucket      (out_beat[g].bucket),
            .ht_out_head_ptr    (out_beat[g].head_ptr),
            .ht_out_head_ptr_val(out_beat[g].head_ptr_val),
            .ht_out_valid       (out_valid[g]),
            .ht_out_ready       (out_ready[g])
        );
    end

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Registered-ready stages may only move ready on a clock edge or a reset change.
    always @(posedge clk) t_edge = $time;
    always @(rst) t_rst = $time;
    always @(in_ready[3]) chk("skid_ready_timing", 128'($time == t_edge || $time == t_rst), 128'd1);

    function automatic beat_t rand_beat();
        beat_t b;
        b.key          = $urandom;
        b.value        = 16'($urandom);
        b.cmd          = ht_cmd_t'(2'($urandom_range(0, 3)));
        b.bucket       = 8'($urandom);
        b.head_ptr     = 10'($urandom);
        b.head_ptr_val = 1'($urandom);
        return b;
    endfunction

    task automatic start(input int idx);
        cur     = idx;
        exp_q.delete();
        acc_q.delete();
        acc_cnt = 0;
        out_cnt = 0;
        ov_cnt  = 0;
        stalled = 1'b0;
        lat_chk = 1'b0;
    endtask

    // Samples both handshakes of the active instance on the falling edge, then
    // advances past the next rising edge.
    task automatic tick();
        beat_t b;
        int    t;
        @(negedge clk);
        in_fired = 1'b0;
        if (stalled) begin
            chk("stall_valid", 128'(out_valid[cur]), 128'd1);
            chk("stall_payload", 128'(out_beat[cur]), 128'(held));
        end
        if (in_valid[cur] && in_ready[cur]) begin
            exp_q.push_back(in_beat[cur]);
            acc_q.push_back(cyc);
            acc_cnt++;
            in_fired = 1'b1;
        end
        if (out_valid[cur] && out_ready[cur]) begin
            out_cnt++;
            chk("beat_expected", 128'(exp_q.size() != 0), 128'd1);
            if (exp_q.size() != 0) begin
                b = exp_q.pop_front();
                t = acc_q.pop_front();
                chk("beat_order_payload", 128'(out_beat[cur]), 128'(b));
                if (lat_chk) chk("latency", 128'(cyc - t), 128'(DLY[cur]));
            end
        end
        if (out_valid[cur]) ov_cnt++;
        stalled = out_valid[cur] && !out_ready[cur];
        held    = out_beat[cur];
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int budget);
        out_ready[cur] = 1'b1;
        in_valid[cur]  = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk("drain_empty", 128'(exp_q.size()), 128'd0);
    endtask

    task automatic rand_run(input int beats, input int budget);
        in_beat[cur]  = rand_beat();
        in_valid[cur] = 1'b1;
        for (int i = 0; i < budget && acc_cnt < beats; i++) begin
            out_ready[cur] = ($urandom_range(0, 2) != 0);
            tick();
            if (in_fired) in_beat[cur] = rand_beat();
            in_valid[cur] = ($urandom_range(0, 3) != 0);
        end
        chk("rand_beats_sent", 128'(acc_cnt >= beats), 128'd1);
        drain(60);
        chk("rand_all_out", 128'(out_cnt), 128'(acc_cnt));
    endtask

    initial begin
        beat_t b;
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '1;
        in_beat   = '0;
        cyc       = 0;
        start(0);
        #2;
        for (int i = 0; i < 4; i++) begin
            chk("rst_out_valid", 128'(out_valid[i]), 128'd0);
            chk("rst_out_payload", 128'(out_beat[i]), 128'd0);
        end
        out_ready = '0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) chk("post_rst_in_ready", 128'(in_ready[i]), 128'd1);
        @(posedge clk);
        #1;
        out_ready = '1;

        // Stream, DELAY=1: keys 1..16 back to back
        start(0);
        lat_chk = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            b        = rand_beat();
            b.key    = 32'(i);
            in_beat[0]  = b;
            in_valid[0] = 1'b1;
            tick();
            chk("stream_accept", 128'(in_fired), 128'd1);
        end
        drain(10);
        chk("stream_count", 128'(out_cnt), 128'd16);

        // Single beat through DELAY=3
        start(1);
        lat_chk = 1'b1;
        b        = rand_beat();
        b.key    = 32'hDEADBEEF;
        b.value  = 16'h1234;
        b.bucket = 8'hA5;
        in_beat[1]  = b;
        in_valid[1] = 1'b1;
        tick();
        in_valid[1] = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("lat_beats_out", 128'(out_cnt), 128'd1);
        chk("lat_valid_cycles", 128'(ov_cnt), 128'd1);

        // Backpressure, DELAY=2 combinational ready
        start(2);
        out_ready[2] = 1'b0;
        in_beat[2]   = rand_beat();
        in_valid[2]  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (in_fired) in_beat[2] = rand_beat();
        end
        chk("bp_accepted", 128'(acc_cnt), 128'd2);
        chk("bp_in_ready", 128'(in_ready[2]), 128'd0);
        out_ready[2] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (in_fired) in_beat[2] = rand_beat();
        end
        drain(10);
        chk("bp_all_out", 128'(out_cnt), 128'(acc_cnt));
        start(2);
        rand_run(200, 3000);

        // Skid stages, DELAY=2: full-stall capacity, throughput, random ready
        start(3);
        out_ready[3] = 1'b0;
        in_beat[3]   = rand_beat();
        in_valid[3]  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (in_fired) in_beat[3] = rand_beat();
        end
        chk("skid_accepted", 128'(acc_cnt), 128'd4);
        chk("skid_in_ready", 128'(in_ready[3]), 128'd0);
        drain(20);
        start(3);
        lat_chk = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_beat[3]  = rand_beat();
            in_valid[3] = 1'b1;
            tick();
            chk("skid_stream_accept", 128'(in_fired), 128'd1);
        end
        drain(10);
        start(3);
        rand_run(1000, 6000);

        // Asynchronous reset with two beats in flight
        start(3);
        out_ready[3] = 1'b0;
        in_beat[3]   = rand_beat();
        in_valid[3]  = 1'b1;
        tick();
        in_beat[3] = rand_beat();
        tick();
        in_valid[3] = 1'b0;
        chk("pre_rst_accepted", 128'(acc_cnt), 128'd2);
        chk("pre_rst_valid", 128'(out_valid[3]), 128'd1);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("async_rst_valid", 128'(out_valid[i]), 128'd0);
            chk("async_rst_payload", 128'(out_beat[i]), 128'd0);
        end
        start(3);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("rst_release_ready", 128'(in_ready[3]), 128'd1);
        out_ready[3] = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("no_stale_beat", 128'(ov_cnt), 128'd0);

        // DELAY=0 pass-through, both ready modes
        for (int idx = 4; idx < 6; idx++) begin
            for (int k = 0; k < 4; k++) begin
                in_beat[idx]   = rand_beat();
                in_valid[idx]  = 1'(k & 1);
                out_ready[idx] = 1'(k >> 1);
                #1;
                chk("wire_payload", 128'(out_beat[idx]), 128'(in_beat[idx]));
                chk("wire_valid", 128'(out_valid[idx]), 128'(in_valid[idx]));
                chk("wire_ready", 128'(in_ready[idx]), 128'(out_ready[idx]));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ht_delay_line.md
# ht_delay_line

Parameterised valid/ready pipeline delay for hash-table command words. It moves one ht_if beat (key, value, cmd, bucket, head_ptr, head_ptr_val) through DELAY register stages without loss, duplication or reordering, and supports downstream backpressure. It is used between hash-table pipeline blocks, for example to register the bucket computed by the hash stage. It can optionally register the ready path so that no combinational path runs from ht_out.ready to ht_in.ready.

## Interface
- KEY_WIDTH, 32: width of key.
- VALUE_WIDTH, 16: width of value.
- BUCKET_WIDTH, 8: width of bucket.
- HEAD_PTR_WIDTH, 10: width of head_ptr.
- DELAY, 1: number of register stages, 0..16.
- PIPELINE_READY, 0: selects the stage type.
  - 0: combinational ready chain.
  - 1: skid-buffer stages with registered ready.

- clk_i, input, 1: single clock; all state updates on its rising edge.
- rst_i, input, 1: asynchronous, active-high reset.
- ht_in, ht_if.slave: upstream beat. Fields: key[KEY_WIDTH], value[VALUE_WIDTH], cmd (ht_cmd_t from package hash_table, passed through opaquely), bucket[BUCKET_WIDTH], head_ptr[HEAD_PTR_WIDTH], head_ptr_val (1), valid (1). This block drives ready (1) back upstream.
- ht_out, ht_if.master: downstream beat with the same fields. This block drives all fields except ready; ready is an input from downstream.

## Operation
- Beat transfer: a beat moves on an interface at a clock edge where valid && ready.
- Payload: all payload fields travel together, bit-exact.
- Each stage k holds a valid flag v[k] and a payload register.

- PIPELINE_READY=0:
  - Stage ready: rdy[k] = !v[k] || rdy[k+1], with rdy[DELAY] = ht_out.ready.
  - When rdy[k] is high, stage k loads stage k-1 (stage 0 loads ht_in).
  - v[k] takes the upstream valid.
  - ht_in.ready = rdy[0], a combinational function of the v flags and ht_out.ready.
  - Bubbles are absorbed: an empty stage accepts even when downstream is stalled.
- PIPELINE_READY=1:
  - Each stage is a 2-entry skid buffer (main register plus skid register).
  - Stage ready output = skid register empty, taken from a flop only.
  - When downstream stalls, the beat arriving in that cycle goes to the skid register.
  - The skid register drains first on the next downstream accept, so order is preserved.
  - ht_in.ready depends only on flops.
- DELAY=0: pure wires. ht_out = ht_in fields and ht_in.ready = ht_out.ready, in both modes.
- Stall stability: while ht_out.valid && !ht_out.ready, all ht_out fields stay constant.
- Reset (rst_i high, asynchronous):
  - All v flags and skid-valid flags clear to 0.
  - All payload registers clear to 0.
  - While in reset: ht_out.valid = 0 and all ht_out payload fields = 0.
  - After release: ht_in.ready = 1 with an empty pipeline. For PIPELINE_READY=0 it is 1 irrespective of ht_out.ready.
- Reset mid-operation: every in-flight beat is discarded; no beat appears on ht_out after reset release unless new input arrives.
- Illegal configuration: DELAY outside 0..16 raises $error at elaboration.

## Timing
- Latency: a beat accepted at edge N appears on ht_out.valid after edge N+DELAY-1, i.e. it is presented during cycle N+DELAY, provided no stalls.
- Throughput: one beat per cycle sustained when ht_out.ready is held at 1, in both modes.
- PIPELINE_READY=0: the ht_out.ready to ht_in.ready path is combinational through DELAY OR gates.
- PIPELINE_READY=1: ht_in.ready drops at most 1 cycle after the pipeline fills.
- Capacity:
  - PIPELINE_READY=0 accepts DELAY beats with ht_out.ready held at 0, then deasserts ht_in.ready.
  - PIPELINE_READY=1 accepts 2*DELAY beats under the same condition.
- Simultaneous events: in the same cycle, a stage being emptied downstream and a new beat from upstream both complete. The stage stays full and no bubble is inserted.

## Test plan
- Stream test, DELAY=1, PIPELINE_READY=0, ht_out.ready=1: send keys 0x00000001..0x00000010 on consecutive cycles. Expected: identical beats on ht_out one cycle later, in order, with bucket, cmd and head_ptr preserved.
- Latency test, DELAY=3: send a single beat with key=0xDEADBEEF, value=0x1234, bucket=0xA5. Expected: ht_out.valid is high for exactly one cycle, 3 cycles after acceptance, with the payload unchanged.
- Backpressure test, DELAY=2, PIPELINE_READY=0: hold ht_out.ready=0 and keep ht_in.valid=1.
  - Expected: exactly 2 beats are accepted, then ht_in.ready=0 and ht_out stays stable.
  - Release ready. Expected: beats drain in order with none lost or duplicated.
- Skid-buffer test, DELAY=2, PIPELINE_READY=1: apply random ready toggling for 1000 beats.
  - Expected: the scoreboard matches with no loss.
  - Expected: 4 beats are accepted under a full stall.
  - Expected: ht_in.ready never changes in a cycle without a clock edge or a reset change.
- Reset test: assert rst_i asynchronously, mid-cycle, with 2 beats in flight.
  - Expected: ht_out.valid goes to 0 immediately and payload fields read 0.
  - Expected: after release, no stale beat is emitted and ht_in.ready=1.
- Pass-through test, DELAY=0: check ht_out equals ht_in combinationally, and that ht_in.ready follows ht_out.ready in the same cycle.
